// File: rtl/pwm_multi_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
//   pwm_mode_e : alignment mode encoding (edge = 0, center = 1)
//   dir_e      : shared counter direction state
//   cnt_width  : register width needed to count 0..n-1 (at least 1 bit)
package pwm_multi_pkg;

  typedef enum logic {
    PWM_MODE_EDGE   = 1'b0,
    PWM_MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Control/data bundle between a PWM client and pwm_multi.
//   en           run enable
//   mode         0 = edge-aligned, 1 = center-aligned
//   load         strobe: capture level into the shadow registers
//   level        channel k duty at [k*W +: W]
//   out          PWM outputs, one per channel
//   period_start 1-clk pulse at each period commit
interface pwm_multi_if #(
  parameter int unsigned C_CHANNELS    = 4,
  parameter int unsigned C_LEVEL_WIDTH = 8
);

  logic                                  en;
  logic                                  mode;
  logic                                  load;
  logic [C_CHANNELS*C_LEVEL_WIDTH-1:0]   level;
  logic [C_CHANNELS-1:0]                 out;
  logic                                  period_start;

  modport master (
    output en, mode, load, level,
    input  out, period_start
  );

  modport slave (
    input  en, mode, load, level,
    output out, period_start
  );

endinterface

// File: rtl/pwm_multi_prescaler.sv
// Tick generator: counts 0..C_PRESCALE-1 while en=1 and flags the wrap cycle.
// Held at zero while en=0, so the first tick after enable is a full prescale
// interval away.
//   clk, rstb : clock, async active-low reset
//   en        : run enable
//   tick_c    : combinational, high in the last cycle of each prescale interval
module pwm_multi_prescaler
  import pwm_multi_pkg::*;
#(
  parameter int unsigned C_PRESCALE = 1
) (
  input  logic clk,
  input  logic rstb,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned   PW   = cnt_width(C_PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(C_PRESCALE - 32'd1);

  logic [PW-1:0] pcnt_q;

  // Prescale counter
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pcnt_q <= '0;
    end else if (!en || (pcnt_q == LAST)) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PW'(1);
    end
  end

  assign tick_c = en && (pcnt_q == LAST);

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a prescaled shared time base, per-channel
// double-buffered duty levels and edge/center alignment.
//   clk, rstb : clock, async active-low reset
//   bus       : pwm_multi_if slave (en, mode, load, level in; out,
//               period_start out, both registered)
// New levels and mode are committed only at a period start, i.e. the tick on
// which the counter sits at 0 heading up, so pulses are never truncated.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int unsigned C_CHANNELS    = 4,
  parameter int unsigned C_LEVEL_WIDTH = 8,
  parameter int unsigned C_PRESCALE    = 1
) (
  input  logic         clk,
  input  logic         rstb,
  pwm_multi_if.slave   bus
);

  localparam int unsigned  W       = C_LEVEL_WIDTH;
  localparam logic [W-1:0] M       = {W{1'b1}};
  localparam logic [W-1:0] CNT_TOP = M - W'(1);

  logic                  tick_c;
  logic                  ps_c;
  dir_e                  state_q, state_d;
  logic [W-1:0]          cnt_q, cnt_d;
  pwm_mode_e             mode_q;
  logic [C_CHANNELS-1:0] hit_c;
  logic [C_CHANNELS-1:0] out_q;
  logic                  ps_q;

  pwm_multi_prescaler #(
    .C_PRESCALE (C_PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rstb   (rstb),
    .en     (bus.en),
    .tick_c (tick_c)
  );

  assign ps_c = tick_c && (cnt_q == '0) && (state_q == DIR_UP);

  // Counter/direction state register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= DIR_UP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: end values are held one extra tick at each turnaround
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.en) begin
      state_d = DIR_UP;
      cnt_d   = '0;
    end else if (tick_c) begin
      if (state_q == DIR_UP) begin
        if (cnt_q == CNT_TOP) begin
          if (mode_q == PWM_MODE_CENTER) begin
            state_d = DIR_DOWN;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          state_d = DIR_UP;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
    end
  end

  // Mode is sampled only at period start
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mode_q <= PWM_MODE_EDGE;
    end else if (ps_c) begin
      mode_q <= pwm_mode_e'(bus.mode);
    end
  end

  for (genvar k = 0; k < C_CHANNELS; k++) begin : g_ch
    logic [W-1:0] level_c;
    logic [W-1:0] shadow_q;
    logic [W-1:0] active_q;
    logic         pending_q;

    assign level_c = bus.level[k*W +: W];

    // Shadow/active double buffer; a load on the commit tick bypasses shadow
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        shadow_q  <= '0;
        active_q  <= '0;
        pending_q <= 1'b0;
      end else begin
        if (bus.load) begin
          shadow_q <= level_c;
        end
        if (bus.load && ps_c) begin
          active_q  <= level_c;
          pending_q <= 1'b0;
        end else if (bus.load) begin
          pending_q <= 1'b1;
        end else if (ps_c && pending_q) begin
          active_q  <= shadow_q;
          pending_q <= 1'b0;
        end
      end
    end

    // Center mode: window [M-level, M-1] straddles the triangle top
    assign hit_c[k] = (mode_q == PWM_MODE_CENTER) ? (cnt_q >= (M - active_q))
                                                  : (cnt_q < active_q);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      out_q <= bus.en ? hit_c : '0;
      ps_q  <= ps_c;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with 2 channels, W=4 (M=15), prescale 2.
// A window runs from the clk after a period_start pulse up to and including
// the next period_start clk; because out lags the counter by one clk, that
// window reflects exactly one committed level/mode.
module tb_pwm_multi;

  localparam int unsigned CH = 2;
  localparam int unsigned W  = 4;
  localparam int unsigned P  = 2;

  typedef struct {
    int len;
    int hi0;
    int hi1;
    int r0;
    int r1;
    int f0;
  } win_t;

  logic clk;
  logic rstb;
  int   n_total = 0;
  int   n_bad   = 0;
  int   n;
  win_t sb[$];

  pwm_multi_if #(.C_CHANNELS(CH), .C_LEVEL_WIDTH(W)) bus();

  pwm_multi #(
    .C_CHANNELS    (CH),
    .C_LEVEL_WIDTH (W),
    .C_PRESCALE    (P)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected window: length, high clks per channel, rising edges, first high index of ch0
  task automatic push(input int len, input int hi0, input int hi1,
                      input int r0, input int r1, input int f0);
    win_t w;
    w.len = len; w.hi0 = hi0; w.hi1 = hi1; w.r0 = r0; w.r1 = r1; w.f0 = f0;
    sb.push_back(w);
  endtask

  // Clks until period_start is seen (bounded); clears any pending load strobe
  task automatic wait_ps(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      bus.load = 1'b0;
      cnt++;
    end while (bus.period_start !== 1'b1 && cnt < 200);
  endtask

  // Measure one window; optionally load levels / change mode at a sample index
  task automatic run_window(input string tag, input int ld_off, input logic [7:0] ld_val,
                            input int md_off, input logic md_val);
    win_t e;
    int   len, hi0, hi1, r0, r1, f0;
    logic p0, p1;
    bit   done;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    len = 0; hi0 = 0; hi1 = 0; r0 = 0; r1 = 0; f0 = 0; p0 = 1'b0; p1 = 1'b0; done = 1'b0;
    while (!done && len < 200) begin
      @(negedge clk);
      len++;
      if (bus.out[0] === 1'b1) begin
        hi0++;
        if (f0 == 0) f0 = len;
      end
      if (bus.out[1] === 1'b1) hi1++;
      if (len > 1 && bus.out[0] === 1'b1 && p0 !== 1'b1) r0++;
      if (len > 1 && bus.out[1] === 1'b1 && p1 !== 1'b1) r1++;
      p0 = bus.out[0];
      p1 = bus.out[1];
      bus.load = (len == ld_off);
      if (len == ld_off) bus.level = ld_val;
      if (len == md_off) bus.mode = md_val;
      if (bus.period_start === 1'b1) done = 1'b1;
    end
    chk({tag, ".len"}, 32'(len), 32'(e.len));
    chk({tag, ".hi0"}, 32'(hi0), 32'(e.hi0));
    chk({tag, ".hi1"}, 32'(hi1), 32'(e.hi1));
    chk({tag, ".rise0"}, 32'(r0), 32'(e.r0));
    chk({tag, ".rise1"}, 32'(r1), 32'(e.r1));
    chk({tag, ".first0"}, 32'(f0), 32'(e.f0));
  endtask

  initial begin
    rstb      = 1'b0;
    bus.en    = 1'b0;
    bus.mode  = 1'b0;
    bus.load  = 1'b0;
    bus.level = '0;
    repeat (2) @(negedge clk);
    chk("rst.out", 32'(bus.out), 32'd0);
    chk("rst.ps", 32'(bus.period_start), 32'd0);
    rstb = 1'b1;
    @(negedge clk);

    // 1: edge, L0=5 L1=10
    bus.en = 1'b1; bus.level = 8'hA5; bus.load = 1'b1;
    push(30, 10, 20, 1, 1, 1);
    push(30, 10, 20, 1, 1, 1);
    wait_ps(n);
    chk("t1.first_ps", 32'(n), 32'd2);
    run_window("t1.w0", -1, 8'h00, -1, 1'b0);
    run_window("t1.w1", -1, 8'h00, -1, 1'b0);

    // 2: L0=0, L1=15 loaded mid-period
    push(30, 10, 20, 1, 1, 1);
    repeat (3) push(30, 0, 30, 0, 0, 0);
    run_window("t2.old", 3, 8'hF0, -1, 1'b0);
    run_window("t2.w0", -1, 8'h00, -1, 1'b0);
    run_window("t2.w1", -1, 8'h00, -1, 1'b0);
    run_window("t2.w2", -1, 8'h00, -1, 1'b0);

    // 3: mid-period load L0=12
    push(30, 0, 30, 0, 0, 0);
    push(30, 24, 30, 1, 0, 1);
    run_window("t3.old", 10, 8'hFC, -1, 1'b0);
    run_window("t3.new", -1, 8'h00, -1, 1'b0);

    // 4: center L0=4, mode toggled mid-period both ways
    push(30, 24, 30, 1, 0, 1);
    push(60, 16, 60, 1, 0, 21);
    push(60, 16, 60, 1, 0, 21);
    push(30, 8, 30, 1, 0, 1);
    run_window("t4.edge_old", 5, 8'hF4, 5, 1'b1);
    run_window("t4.center", -1, 8'h00, -1, 1'b0);
    run_window("t4.center_hold", -1, 8'h00, 20, 1'b0);
    run_window("t4.edge_back", -1, 8'h00, -1, 1'b0);

    // 5: load on the period_start clk (L0=7, L1=3) commits immediately
    push(30, 8, 30, 1, 0, 1);
    push(30, 14, 6, 1, 1, 1);
    push(30, 14, 6, 1, 1, 1);
    run_window("t5.old", 29, 8'h37, -1, 1'b0);
    run_window("t5.bypass", -1, 8'h00, -1, 1'b0);
    run_window("t5.after", -1, 8'h00, -1, 1'b0);

    // 6: async reset mid-pulse, idle, re-enable
    @(negedge clk);
    @(negedge clk);
    chk("t6.pre_rst", 32'(bus.out), 32'd3);
    rstb = 1'b0; bus.en = 1'b0;
    #1;
    chk("t6.async_out", 32'(bus.out), 32'd0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t6.idle", 32'({bus.period_start, bus.out}), 32'd0);
    end
    bus.en = 1'b1;
    push(30, 0, 0, 0, 0, 0);
    wait_ps(n);
    chk("t6.reen_ps", 32'(n), 32'd2);
    run_window("t6.noload", -1, 8'h00, -1, 1'b0);
    bus.en = 1'b0; bus.level = 8'hA5; bus.load = 1'b1;
    repeat (6) begin
      @(negedge clk);
      bus.load = 1'b0;
      chk("t6.dis", 32'({bus.period_start, bus.out}), 32'd0);
    end
    bus.en = 1'b1;
    push(30, 10, 20, 1, 1, 1);
    wait_ps(n);
    chk("t6.reen2_ps", 32'(n), 32'd2);
    run_window("t6.pending", -1, 8'h00, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
